// File: rtl/aes192_dec_round_ctrl.sv
// Iterative AES-192 decryption controller: one shared inverse-round datapath, 13 cycles per block.
// Optional synchronous `abort` input is compiled in when AES_DEC_ABORT_EN is defined.
module aes192_dec_round_ctrl (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_DEC_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain_out,
  output logic         busy
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_e;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xt(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse computed as x^254 with an addition chain; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    return gf_mul(x127, x127);
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a;
    a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31 - 8*i -: 8];
      m2[i]  = xt(a[i]);
      m4[i]  = xt(m2[i]);
      m8[i]  = xt(m4[i]);
      m9[i]  = m8[i] ^ a[i];
      m11[i] = m8[i] ^ m2[i] ^ a[i];
      m13[i] = m8[i] ^ m4[i] ^ a[i];
      m14[i] = m8[i] ^ m4[i] ^ m2[i];
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
    return o;
  endfunction

  state_e       fsm_q, fsm_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   rk_idx_q, rk_idx_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;
  logic         abort_hit;
  logic [127:0] final_out;
  logic [127:0] round_out;

`ifdef AES_DEC_ABORT_EN
  assign abort_hit = abort && (fsm_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Final round is the shared path tapped before InvMixColumns.
  assign final_out = inv_sub_bytes(inv_shift_rows(st_q)) ^ round_key;
  assign round_out = inv_mix_columns(final_out);

  always_comb begin
    fsm_d = fsm_q;
    st_d  = st_q;
    cnt_d = cnt_q;
    case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d  = cipher_in ^ round_key;
          cnt_d = 4'd11;
          fsm_d = S_ROUND;
        end
      end
      S_ROUND: begin
        st_d = round_out;
        if (cnt_q == 4'd1) begin
          cnt_d = 4'd0;
          fsm_d = S_FINAL;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_FINAL: begin
        st_d  = final_out;
        fsm_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
    if (abort_hit) begin
      fsm_d = S_IDLE;
      st_d  = '0;
      cnt_d = '0;
    end

    // Outputs are registered, decoded from the next state.
    in_ready_d  = (fsm_d == S_IDLE);
    out_valid_d = (fsm_d == S_DONE);
    busy_d      = (fsm_d == S_ROUND) || (fsm_d == S_FINAL);
    case (fsm_d)
      S_IDLE:  rk_idx_d = 4'd12;
      S_ROUND: rk_idx_d = cnt_d;
      default: rk_idx_d = 4'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= S_IDLE;
      st_q        <= '0;
      cnt_q       <= '0;
      rk_idx_q    <= 4'd12;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      rk_idx_q    <= rk_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign rk_idx    = rk_idx_q;
  assign plain_out = st_q;

endmodule

// File: tb/tb_aes192_dec_round_ctrl.sv
// Scoreboard bench for aes192_dec_round_ctrl with a table-driven AES-192 reference model.
`timescale 1ns/1ps
module tb_aes192_dec_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] cipher_in = '0;
  logic         abort_i = 1'b0;
  logic         out_ready;
  logic         in_ready, out_valid, busy;
  logic [3:0]   rk_idx;
  logic [127:0] round_key, plain_out;

  logic [127:0] rks [13];
  logic [7:0]   sbox [256];
  logic [7:0]   isbox [256];
  logic [127:0] exp_q [$];
  int           nvec = 0;
  int           nerr = 0;
  logic         sink_rand = 1'b0;
  logic         manual_ready = 1'b1;
  logic         rand_ready = 1'b1;

  always #5 clk = ~clk;

  assign out_ready = sink_rand ? rand_ready : manual_ready;
  assign round_key = (rk_idx <= 4'd12) ? rks[rk_idx] : '0;

  aes192_dec_round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef AES_DEC_ABORT_EN
    .abort     (abort_i),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cipher_in (cipher_in),
    .rk_idx    (rk_idx),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .plain_out (plain_out),
    .busy      (busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x, y;
    r = 0; x = a; y = b;
    while (y != 0) begin
      if (y[0]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x] = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic expand(input logic [191:0] key);
    logic [31:0] w [52];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 6; i++) w[i] = key[191 - 32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-6] ^ t;
    end
    for (int r = 0; r < 13; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_dec(input logic [127:0] ct);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   coef [4];
    logic [127:0] o;
    coef = '{8'd14, 8'd11, 8'd13, 8'd9};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = ct[127 - 8*(4*c+r) -: 8] ^ rks[12][127 - 8*(4*c+r) -: 8];
    for (int rnd = 11; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = isbox[s[r][(c - r + 4) % 4]] ^ rks[rnd][127 - 8*(4*c+r) -: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd > 0) begin
            s[r][c] = 0;
            for (int k = 0; k < 4; k++) s[r][c] = s[r][c] ^ gmul(t[k][c], coef[(k - r + 4) % 4]);
          end else begin
            s[r][c] = t[r][c];
          end
        end
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127 - 8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !abort_i) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_output: got %h expected no block", plain_out);
      end else begin
        check("plaintext", plain_out, exp_q.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    rand_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  // ---------------- stimulus helpers (call at posedge+1) ----------------
  task automatic send(input logic [127:0] ct, input bit push, input logic [127:0] expv);
    int guard;
    guard = 0;
    in_valid  = 1'b1;
    cipher_in = ct;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("accept_timeout", 128'(in_ready), 128'(1));
    @(posedge clk);
    if (push) exp_q.push_back(expv);
    #1;
    in_valid  = 1'b0;
    cipher_in = rand128();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 128'(exp_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic latency_check(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 40);
    check(name, 128'(k), 128'(13));
  endtask

  task automatic junk_pulses();
    for (int k = 0; k < 10; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      cipher_in = rand128();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_plain_out"}, plain_out, 128'(0));
    check({tag, "_rk_idx"}, 128'(rk_idx), 128'(12));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] ct, ev;
    for (int r = 0; r < 13; r++) rks[r] = '0;
    build_tables();
    #12;
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known-answer vector with per-cycle rk_idx / busy / out_valid trace.
    expand(192'h000102030405060708090a0b0c0d0e0f1011121314151617);
    in_valid  = 1'b1;
    cipher_in = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    @(negedge clk);
    check("kat_rk_idx_c0", 128'(rk_idx), 128'(12));
    check("kat_in_ready_c0", 128'(in_ready), 128'(1));
    @(posedge clk);
    exp_q.push_back(128'h00112233445566778899aabbccddeeff);
    #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      check($sformatf("kat_rk_idx_c%0d", k), 128'(rk_idx), 128'((k <= 11) ? 12 - k : 0));
      check($sformatf("kat_out_valid_c%0d", k), 128'(out_valid), 128'(k == 13));
      check($sformatf("kat_busy_c%0d", k), 128'(busy), 128'(k <= 12));
    end
    @(negedge clk);
    check("kat_out_valid_after_hs", 128'(out_valid), 128'(0));
    check("kat_in_ready_after_hs", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;

    // Backpressure: out_valid and plaintext held for 20 cycles.
    expand({rand128(), $urandom(), $urandom()});
    ct = rand128();
    ev = model_dec(ct);
    manual_ready = 1'b0;
    send(ct, 1'b1, ev);
    latency_check("bp_latency");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("bp_out_valid_held", 128'(out_valid), 128'(1));
      check("bp_plain_stable", plain_out, ev);
    end
    @(posedge clk);
    #1;
    manual_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_out_valid_fall", 128'(out_valid), 128'(0));
    check("bp_in_ready_rise", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;

    // Busy input: stray in_valid pulses with other data are ignored.
    ct = rand128();
    send(ct, 1'b1, model_dec(ct));
    junk_pulses();
    drain();

    // Reset mid-decryption discards the block.
    send(rand128(), 1'b0, '0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ct = rand128();
    send(ct, 1'b1, model_dec(ct));
    latency_check("post_reset_latency");
    drain();

`ifdef AES_DEC_ABORT_EN
    // Abort mid-round, then abort in DONE coincident with out_ready.
    send(rand128(), 1'b0, '0);
    repeat (4) @(posedge clk);
    #1;
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort_round");
    @(posedge clk);
    #1;
    manual_ready = 1'b0;
    send(rand128(), 1'b0, '0);
    latency_check("abort_done_latency");
    @(posedge clk);
    #1;
    abort_i = 1'b1;
    manual_ready = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    @(negedge clk);
    check("abort_done_out_valid", 128'(out_valid), 128'(0));
    check("abort_done_in_ready", 128'(in_ready), 128'(1));
    check("abort_done_plain", plain_out, 128'(0));
    @(posedge clk);
    #1;
    ct = rand128();
    send(ct, 1'b1, model_dec(ct));
    drain();
`endif

    // Randomised stream with random backpressure and key changes.
    sink_rand = 1'b1;
    for (int n = 0; n < 12; n++) begin
      if (n % 3 == 0) begin
        drain();
        expand({rand128(), $urandom(), $urandom()});
      end
      ct = rand128();
      send(ct, 1'b1, model_dec(ct));
      if ($urandom_range(0, 1) == 1) junk_pulses();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();
    sink_rand = 1'b0;
    repeat (3) @(posedge clk);
    check("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
